// File: rtl/ai_i2s_pkg.sv
// Shared types and default parameters for the ping-pong I2S transmitter.
package ai_i2s_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_HALF_DEPTH = 8;
  localparam int DEF_CLK_DIV    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ai_i2s_sck_gen.sv
// Bit-clock generator: divides clk down to SCK and flags the clk cycle that
// ends with an SCK falling edge, so the transmitter can update sd/ws on the
// same posedge that SCK drops.
module ai_i2s_sck_gen
  import ai_i2s_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic fall_evt
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          terminal;

  // A half-period ends when the divider reaches its last count while running.
  always_comb begin
    terminal = run && (div_cnt == DIV_LAST);
    fall_evt = terminal && sck;
  end

  // Divider and SCK level; both held at zero whenever not running so the
  // first toggle after start is always a rise, CLK_DIV cycles in.
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ai_i2s_tx_pingpong.sv
// I2S transmitter reading stereo frames from a two-half ping-pong buffer.
// Software fills one half while the other is being played; each half has a
// full flag set by fill_done_x and cleared when its last frame is loaded.
module ai_i2s_tx_pingpong
  import ai_i2s_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int HALF_DEPTH = DEF_HALF_DEPTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tx_en,
  input  logic                            wr_en,
  input  logic [$clog2(2*HALF_DEPTH)-1:0] wr_addr,
  input  logic [2*DATA_W-1:0]             wr_data,
  input  logic                            fill_done_low,
  input  logic                            fill_done_high,
  output logic                            i2s_sck,
  output logic                            i2s_ws,
  output logic                            i2s_sd,
  output logic                            low_buf_empty,
  output logic                            high_buf_empty,
  output logic                            underrun
);

  localparam int AW = $clog2(2*HALF_DEPTH);
  localparam int FW = 2*DATA_W;
  localparam int BW = $clog2(FW);
  localparam logic [BW-1:0] LAST_SLOT = BW'(FW - 1);
  localparam logic [BW-1:0] WS_FIRST  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] WS_LAST   = BW'(FW - 2);

  state_t        state;
  logic          run;
  logic          sck;
  logic          fall_evt;
  logic          started;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_nxt;
  logic          frame_start;
  logic          ws;
  logic [FW-1:0] shift_reg;
  logic [FW-1:0] load_word;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    half_full;
  logic [1:0]    clr_mask;
  logic          cur_full;
  logic          last_of_half;

  logic [FW-1:0] mem [2*HALF_DEPTH];

  // The divider only runs while RUN is held; dropping tx_en stops it on the
  // same edge the FSM leaves RUN, so SCK is low the very next cycle.
  assign run = (state == RUN) && tx_en;

  ai_i2s_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .sck      (sck),
    .fall_evt (fall_evt)
  );

  // Frame bookkeeping: next slot number, frame-start detection, what to load
  // and which half (if any) gets released by this load.
  always_comb begin
    frame_start  = fall_evt && (!started || (bit_cnt == LAST_SLOT));
    bit_nxt      = (!started || (bit_cnt == LAST_SLOT)) ? '0 : bit_cnt + 1'b1;
    cur_full     = half_full[rd_ptr[AW-1]];
    last_of_half = &rd_ptr[AW-2:0];
    load_word    = cur_full ? mem[rd_ptr] : '0;
    clr_mask     = 2'b00;
    if (frame_start && cur_full && last_of_half) begin
      clr_mask[rd_ptr[AW-1]] = 1'b1;
    end
  end

  // Frame storage: writes land in any state and are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Half-full flags: fill_done sets, consuming the last frame clears, and a
  // clear in the same cycle as a fill on that half wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_full <= 2'b00;
    end else begin
      half_full <= (half_full | {fill_done_high, fill_done_low}) & ~clr_mask;
    end
  end

  // Transmit FSM: owns slot counter, shifter, word select, read pointer and
  // the underrun pulse; everything returns to zero whenever we are not in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      started   <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      ws        <= 1'b0;
      rd_ptr    <= '0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          started   <= 1'b0;
          bit_cnt   <= '0;
          shift_reg <= '0;
          ws        <= 1'b0;
          rd_ptr    <= '0;
          if (tx_en) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!tx_en) begin
            state     <= IDLE;
            started   <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ws        <= 1'b0;
            rd_ptr    <= '0;
          end else if (fall_evt) begin
            started <= 1'b1;
            bit_cnt <= bit_nxt;
            ws      <= (bit_nxt >= WS_FIRST) && (bit_nxt <= WS_LAST);
            if (frame_start) begin
              shift_reg <= load_word;
              if (cur_full) begin
                rd_ptr <= rd_ptr + 1'b1;
              end else begin
                underrun <= 1'b1;
              end
            end else begin
              shift_reg <= shift_reg << 1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign i2s_sck        = sck;
  assign i2s_ws         = ws;
  assign i2s_sd         = shift_reg[FW-1];
  assign low_buf_empty  = ~half_full[0];
  assign high_buf_empty = ~half_full[1];

endmodule

// File: tb/tb_ai_i2s_tx_pingpong.sv
// Directed bench for the ping-pong I2S transmitter (DATA_W=16, HALF_DEPTH=2,
// CLK_DIV=2). Serial slots are captured on every SCK rise.
module tb_ai_i2s_tx_pingpong;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_en;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        fill_done_low;
  logic        fill_done_high;
  logic        i2s_sck;
  logic        i2s_ws;
  logic        i2s_sd;
  logic        low_buf_empty;
  logic        high_buf_empty;
  logic        underrun;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ur_cnt  = 0;

  logic prev_sck = 1'b0;
  logic sd_q[$];
  logic ws_q[$];

  logic [63:0] a_d, a_w, b_d, b_w;

  ai_i2s_tx_pingpong #(
    .DATA_W     (16),
    .HALF_DEPTH (2),
    .CLK_DIV    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_en          (tx_en),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .fill_done_low  (fill_done_low),
    .fill_done_high (fill_done_high),
    .i2s_sck        (i2s_sck),
    .i2s_ws         (i2s_ws),
    .i2s_sd         (i2s_sd),
    .low_buf_empty  (low_buf_empty),
    .high_buf_empty (high_buf_empty),
    .underrun       (underrun)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Capture sd/ws at each SCK rise and count underrun pulses.
  always @(negedge clk) begin
    if (i2s_sck === 1'b1 && prev_sck === 1'b0) begin
      sd_q.push_back(i2s_sd);
      ws_q.push_back(i2s_ws);
    end
    prev_sck = i2s_sck;
    if (underrun === 1'b1) ur_cnt++;
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vec_cnt++;
    if (observed !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Write one stereo frame into the buffer.
  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk); #1;
    wr_en   = 1'b0;
  endtask

  // Wait (bounded) for the next captured SCK-rise slot.
  task automatic getSlot(output logic sd_v, output logic ws_v);
    int waited = 0;
    while (sd_q.size() == 0 && waited < 64) begin
      @(negedge clk); #1;
      waited++;
    end
    if (sd_q.size() == 0) begin
      checkOutput("slot_timeout", 64'(sd_q.size()), 64'd1);
      sd_v = 1'b0;
      ws_v = 1'b0;
    end else begin
      sd_v = sd_q.pop_front();
      ws_v = ws_q.pop_front();
    end
  endtask

  // Collect n slots MSB-first into d (data) and w (word select).
  task automatic getBits(input int n, output logic [63:0] d, output logic [63:0] w);
    logic s, x;
    d = '0;
    w = '0;
    for (int i = 0; i < n; i++) begin
      getSlot(s, x);
      d = {d[62:0], s};
      w = {w[62:0], x};
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    tx_en          = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = 2'd0;
    wr_data        = 32'd0;
    fill_done_low  = 1'b0;
    fill_done_high = 1'b0;

    // Reset with tx_en low
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_sck", 64'(i2s_sck), 64'd0);
    checkOutput("rst_ws", 64'(i2s_ws), 64'd0);
    checkOutput("rst_sd", 64'(i2s_sd), 64'd0);
    checkOutput("rst_underrun", 64'(underrun), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_low_empty", 64'(low_buf_empty), 64'd1);
    checkOutput("rst_high_empty", 64'(high_buf_empty), 64'd1);
    checkOutput("rst_no_underrun", 64'(ur_cnt), 64'd0);

    // Load all four frames, flag only the low half, then start
    applyStimulus(2'd0, 32'hA5A5_0001);
    applyStimulus(2'd1, 32'h8000_7FFF);
    applyStimulus(2'd2, 32'h1234_5678);
    applyStimulus(2'd3, 32'h5AC3_F00F);
    fill_done_low = 1'b1;
    @(negedge clk); #1;
    fill_done_low = 1'b0;
    checkOutput("fill_low_empty", 64'(low_buf_empty), 64'd0);
    checkOutput("fill_high_empty", 64'(high_buf_empty), 64'd1);
    sd_q.delete();
    ws_q.delete();
    tx_en = 1'b1;

    // One SCK rise precedes the first frame, with nothing on the line yet
    getBits(1, a_d, a_w);
    checkOutput("lead_sd", a_d, 64'd0);
    checkOutput("lead_ws", a_w, 64'd0);

    getBits(32, a_d, a_w);
    checkOutput("f0_data", a_d, 64'hA5A5_0001);
    checkOutput("f0_ws", a_w, 64'h0001_FFFE);
    checkOutput("f0_low_empty", 64'(low_buf_empty), 64'd0);

    getBits(1, a_d, a_w);
    checkOutput("f1_low_empty", 64'(low_buf_empty), 64'd1);
    getBits(31, b_d, b_w);
    checkOutput("f1_data", 64'({a_d[0], b_d[30:0]}), 64'h8000_7FFF);
    checkOutput("f1_ws", 64'({a_w[0], b_w[30:0]}), 64'h0001_FFFE);

    // Third frame: high half unfilled, expect underrun and zeros
    getBits(1, a_d, a_w);
    checkOutput("ur_pulse", 64'(ur_cnt), 64'd1);
    checkOutput("ur_high_empty_pre", 64'(high_buf_empty), 64'd1);
    fill_done_high = 1'b1;
    @(negedge clk);
    fill_done_high = 1'b0;
    #1;
    checkOutput("ur_high_empty_post", 64'(high_buf_empty), 64'd0);
    getBits(31, b_d, b_w);
    checkOutput("ur_zero_data", 64'({a_d[0], b_d[30:0]}), 64'd0);
    checkOutput("ur_single_pulse", 64'(ur_cnt), 64'd1);

    // rd_ptr held at 2, so frame 2 follows
    getBits(32, a_d, a_w);
    checkOutput("f2_data", a_d, 64'h1234_5678);

    // Frame 3 empties the high half; abort in slot 9
    getBits(1, a_d, a_w);
    checkOutput("f3_high_empty", 64'(high_buf_empty), 64'd1);
    getBits(9, b_d, b_w);
    checkOutput("f3_slots0to9", 64'({a_d[0], b_d[8:0]}), 64'h16B);
    tx_en = 1'b0;
    @(negedge clk); #1;
    checkOutput("abort_sck", 64'(i2s_sck), 64'd0);
    checkOutput("abort_ws", 64'(i2s_ws), 64'd0);
    checkOutput("abort_sd", 64'(i2s_sd), 64'd0);

    repeat (5) @(negedge clk);
    #1;
    checkOutput("idle_underrun_cnt", 64'(ur_cnt), 64'd1);
    checkOutput("idle_low_empty", 64'(low_buf_empty), 64'd1);
    checkOutput("idle_high_empty", 64'(high_buf_empty), 64'd1);

    // Refill low half and restart: playback resumes at address 0
    fill_done_low = 1'b1;
    @(negedge clk); #1;
    fill_done_low = 1'b0;
    checkOutput("refill_low_empty", 64'(low_buf_empty), 64'd0);
    sd_q.delete();
    ws_q.delete();
    tx_en = 1'b1;
    getBits(1, a_d, a_w);
    getBits(32, a_d, a_w);
    checkOutput("re_f0_data", a_d, 64'hA5A5_0001);
    checkOutput("re_f0_low_empty", 64'(low_buf_empty), 64'd0);

    // fill_done_low coincides with the load of frame 1: clear must win
    @(negedge clk);
    fill_done_low = 1'b1;
    @(negedge clk);
    fill_done_low = 1'b0;
    #1;
    checkOutput("clear_wins_low_empty", 64'(low_buf_empty), 64'd1);
    getBits(32, a_d, a_w);
    checkOutput("re_f1_data", a_d, 64'h8000_7FFF);
    tx_en = 1'b0;
    @(negedge clk); #1;
    checkOutput("final_underrun_cnt", 64'(ur_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
